controle_envase: RTL and testbench
==================================

# controle_envase

Sequencing controller for the bottle filling line: drives the conveyor, filling valve, capping actuator and reject gate from the station sensors. It counts approved bottles modulo 12 and emits one single-cycle `pulso_duzia` per completed dozen. That pulse feeds the dozen counter's `incrementar` input. The controller sits between the synchronised field I/O and the dozen counter/display path, all in the 50 MHz `clk` domain.

## Interface
- `T_ENCHER_MAX`, default 250_000_000: fill timeout in cycles (5 s); expiry raises a fault.
- `T_VEDAR`, default 50_000_000: capping actuator on-time in cycles (1 s).
- `clk`  in  1  50 MHz system clock
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  START button, raw/asynchronous
- `stop`  in  1  STOP button, raw/asynchronous
- `sensor_posicao`  in  1  bottle present at filling station, raw
- `sensor_nivel`  in  1  fill level reached, raw
- `cq_valido`  in  1  quality-check result valid, raw
- `cq_aprovado`  in  1  quality-check verdict (1 = approved); sampled when `cq_valido` is high
- `motor`  out  1  conveyor run
- `valvula`  out  1  fill valve open
- `vedacao`  out  1  capping actuator
- `descarte`  out  1  reject gate, one-cycle pulse
- `pulso_duzia`  out  1  one-cycle pulse per 12 approved bottles
- `garrafas`  out  4  approved bottles in current dozen, 0–11
- `alarme`  out  1  fault indicator
- `estado`  out  3  current state encoding, for debug/display

## Operation
- Every raw input passes a 2-FF synchroniser. `start`, `stop`, `sensor_posicao` and `cq_valido` also get rising-edge detection (`*_sub` below). `sensor_nivel` and `cq_aprovado` are used as synchronised levels.
- States are OCIOSO, ESTEIRA, ENCHENDO, VEDANDO, INSPECAO and FALHA.
- OCIOSO: all actuators off.
  - `start_sub` → ESTEIRA.
  - `start_sub` also clears `garrafas` to 0, matching the dozen counter's clear on START.
- ESTEIRA: `motor`=1. `sensor_posicao_sub` → ENCHENDO.
  - Only the rising edge triggers, so a bottle still present after inspection does not retrigger.
- ENCHENDO: `motor`=0, `valvula`=1, timer runs.
  - `sensor_nivel`=1 → VEDANDO; timer clears.
  - Timer = `T_ENCHER_MAX`-1 without level → FALHA.
- VEDANDO: `vedacao`=1 for exactly `T_VEDAR` cycles, then → INSPECAO.
- INSPECAO: all actuators off; waits for `cq_valido_sub`.
  - If approved: `garrafas`+1.
  - If `garrafas` was 11 and the bottle is approved: `garrafas`←0 and `pulso_duzia`=1.
  - If rejected: `descarte`=1 for one cycle.
  - Either verdict → ESTEIRA.
- FALHA: all actuators off, `alarme`=1. `start_sub` → OCIOSO and clears `alarme`. `stop` has no effect.
- `stop_sub` in any state except OCIOSO and FALHA → OCIOSO on the next edge. The valve closes and the motor stops in that same transition. `garrafas` is retained.
- Priority: reset > `stop_sub` > timeout > `start_sub`/sensor events.
  - `stop_sub` coincident with an INSPECAO verdict: stop wins, no count change, no pulses.
  - `start_sub` and `stop_sub` in the same cycle in OCIOSO: remain OCIOSO.
- Timer width is `$clog2(max(T_ENCHER_MAX, T_VEDAR))` bits, shared by ENCHENDO and VEDANDO. It clears on every state entry.
- `garrafas` is 4-bit and never exceeds 11.

## Timing
- Reset values:
  - `estado`=OCIOSO.
  - `motor`, `valvula`, `vedacao`, `descarte`, `pulso_duzia`, `alarme` = 0.
  - `garrafas`=0; synchroniser and timer flops = 0.
- All outputs are registered; `motor`, `valvula`, `vedacao` and `alarme` decode directly from the registered state.
- Latency from raw input edge to state change is 3 clocks: 2 synchroniser flops plus 1 state register.
- `pulso_duzia` and `descarte` assert on the same edge as the INSPECAO → ESTEIRA transition. Each is high for exactly one cycle.
- Asynchronous reset mid-operation drops all actuators immediately (asynchronously) and returns to OCIOSO.

## Structure
- Shared package `envase_pkg` holds the state encoding (3-bit localparams), `DUZIA`=12 and the default timing constants.
- Sub-module `sincronizador_borda`: 2-FF synchroniser plus rising-edge detector, exposing `nivel` and `borda` outputs. It is instantiated once per raw input.
- The FSM, timer and modulo-12 counter live in `controle_envase`.

## Test plan
All scenarios use `T_ENCHER_MAX`=20 and `T_VEDAR`=5.
- **Normal cycle:** `start` pulse, `sensor_posicao` rise, `sensor_nivel` after 8 cycles, then `cq_valido` with approved.
  - Expect `motor` on; then `valvula` high for 8 synchronised cycles; `vedacao` high for exactly 5 cycles; `garrafas`=1; `motor` back on.
- **Dozen wrap:** 12 approved bottles.
  - Expect one `pulso_duzia` cycle coincident with `garrafas` 11→0; no pulse on the 11 preceding bottles.
- **Reject:** 3 approved, 1 rejected, 1 approved.
  - Expect a single `descarte` pulse on the rejected bottle; `garrafas`=4.
- **Fill timeout:** no `sensor_nivel` after `sensor_posicao`.
  - Expect FALHA after 20 cycles in ENCHENDO with `alarme`=1 and `valvula`=0.
  - `stop` is ignored; `start` → OCIOSO with `alarme`=0.
- **Stop:** `stop` during ENCHENDO.
  - Expect OCIOSO with `valvula`=0 three clocks after the raw edge; `garrafas` unchanged.
  - A following `start` clears `garrafas` to 0.
- **Reset / simultaneous events:**
  - Async `reset` mid-VEDANDO: all outputs 0 without waiting for a clock edge.
  - `stop` and verdict in the same cycle: no count change, no pulses.

Source files
------------

// File: rtl/envase_pkg.sv
// Shared definitions for the bottle filling line controller:
// state encoding, bottles per dozen, default timing constants and the
// timer width helper.
package envase_pkg;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ESTEIRA  = 3'd1,
    ENCHENDO = 3'd2,
    VEDANDO  = 3'd3,
    INSPECAO = 3'd4,
    FALHA    = 3'd5
  } estado_t;

  localparam int unsigned DUZIA = 12;

  // 50 MHz clock: 5 s fill timeout, 1 s capping time.
  localparam int unsigned T_ENCHER_MAX_PADRAO = 250_000_000;
  localparam int unsigned T_VEDAR_PADRAO      = 50_000_000;

  // Width of the shared fill/capping timer: enough bits for the larger limit.
  function automatic int unsigned largura_timer(input int unsigned a,
                                                input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sincronizador_borda.sv
// 2-FF synchroniser for one raw field input plus rising-edge detector.
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   entrada     raw/asynchronous input
//   nivel       synchronised level
//   borda       one-cycle pulse on a synchronised rising edge
module sincronizador_borda (
  input  logic clk,
  input  logic reset,
  input  logic entrada,
  output logic nivel,
  output logic borda
);

  logic meta;
  logic sinc;
  logic anterior;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta     <= 1'b0;
      sinc     <= 1'b0;
      anterior <= 1'b0;
    end else begin
      meta     <= entrada;
      sinc     <= meta;
      anterior <= sinc;
    end
  end

  assign nivel = sinc;
  // Edge is combinational from the second flop so the state register
  // reacts on the third clock after the raw edge.
  assign borda = sinc & ~anterior;

endmodule

// File: rtl/controle_envase.sv
// Sequencing controller for the bottle filling line. Drives conveyor,
// fill valve, capping actuator and reject gate from the station sensors,
// counts approved bottles modulo 12 and pulses pulso_duzia per dozen.
// Ports:
//   clk, reset       50 MHz clock, asynchronous active-high reset
//   start, stop      raw push buttons
//   sensor_posicao   bottle present at filling station (raw)
//   sensor_nivel     fill level reached (raw)
//   cq_valido        quality-check result valid (raw)
//   cq_aprovado      quality-check verdict, 1 = approved (raw)
//   motor            conveyor run
//   valvula          fill valve open
//   vedacao          capping actuator
//   descarte         reject gate, one-cycle pulse
//   pulso_duzia      one-cycle pulse per 12 approved bottles
//   garrafas         approved bottles in the current dozen, 0..11
//   alarme           fault indicator
//   estado           current state encoding
module controle_envase
  import envase_pkg::*;
#(
  parameter int unsigned T_ENCHER_MAX = T_ENCHER_MAX_PADRAO,
  parameter int unsigned T_VEDAR      = T_VEDAR_PADRAO
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       sensor_posicao,
  input  logic       sensor_nivel,
  input  logic       cq_valido,
  input  logic       cq_aprovado,
  output logic       motor,
  output logic       valvula,
  output logic       vedacao,
  output logic       descarte,
  output logic       pulso_duzia,
  output logic [3:0] garrafas,
  output logic       alarme,
  output logic [2:0] estado
);

  localparam int unsigned TW = largura_timer(T_ENCHER_MAX, T_VEDAR);
  localparam logic [TW-1:0] FIM_ENCHER = TW'(T_ENCHER_MAX - 1);
  localparam logic [TW-1:0] FIM_VEDAR  = TW'(T_VEDAR - 1);
  localparam logic [3:0]    ULTIMA     = 4'(DUZIA - 1);

  logic start_sub, stop_sub, posicao_sub, cq_sub;
  logic nivel, aprovado;
  logic start_niv, stop_niv, posicao_niv, cq_niv;
  logic nivel_borda, aprovado_borda;

  sincronizador_borda u_sinc_start (
    .clk(clk), .reset(reset), .entrada(start),
    .nivel(start_niv), .borda(start_sub)
  );
  sincronizador_borda u_sinc_stop (
    .clk(clk), .reset(reset), .entrada(stop),
    .nivel(stop_niv), .borda(stop_sub)
  );
  sincronizador_borda u_sinc_posicao (
    .clk(clk), .reset(reset), .entrada(sensor_posicao),
    .nivel(posicao_niv), .borda(posicao_sub)
  );
  sincronizador_borda u_sinc_nivel (
    .clk(clk), .reset(reset), .entrada(sensor_nivel),
    .nivel(nivel), .borda(nivel_borda)
  );
  sincronizador_borda u_sinc_cq_valido (
    .clk(clk), .reset(reset), .entrada(cq_valido),
    .nivel(cq_niv), .borda(cq_sub)
  );
  sincronizador_borda u_sinc_cq_aprovado (
    .clk(clk), .reset(reset), .entrada(cq_aprovado),
    .nivel(aprovado), .borda(aprovado_borda)
  );

  // Synchroniser outputs this controller has no use for.
  logic unused_sinais;
  assign unused_sinais = &{1'b0, start_niv, stop_niv, posicao_niv, cq_niv,
                           nivel_borda, aprovado_borda};

  estado_t       atual, proximo;
  logic [TW-1:0] timer, timer_prox;
  logic [3:0]    cont, cont_prox;
  logic          descarte_r, descarte_prox;
  logic          pulso_r, pulso_prox;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      atual      <= OCIOSO;
      timer      <= '0;
      cont       <= '0;
      descarte_r <= 1'b0;
      pulso_r    <= 1'b0;
    end else begin
      atual      <= proximo;
      timer      <= timer_prox;
      cont       <= cont_prox;
      descarte_r <= descarte_prox;
      pulso_r    <= pulso_prox;
    end
  end

  // Branch order inside each state encodes stop > timeout > events.
  always_comb begin
    proximo       = atual;
    cont_prox     = cont;
    descarte_prox = 1'b0;
    pulso_prox    = 1'b0;
    timer_prox    = '0;

    case (atual)
      OCIOSO: begin
        if (start_sub && !stop_sub) begin
          proximo   = ESTEIRA;
          cont_prox = '0;
        end
      end
      ESTEIRA: begin
        if (stop_sub)         proximo = OCIOSO;
        else if (posicao_sub) proximo = ENCHENDO;
      end
      ENCHENDO: begin
        if (stop_sub)                 proximo = OCIOSO;
        else if (timer == FIM_ENCHER) proximo = FALHA;
        else if (nivel)               proximo = VEDANDO;
      end
      VEDANDO: begin
        if (stop_sub)                proximo = OCIOSO;
        else if (timer == FIM_VEDAR) proximo = INSPECAO;
      end
      INSPECAO: begin
        if (stop_sub) begin
          proximo = OCIOSO;
        end else if (cq_sub) begin
          proximo = ESTEIRA;
          if (aprovado) begin
            if (cont == ULTIMA) begin
              cont_prox  = '0;
              pulso_prox = 1'b1;
            end else begin
              cont_prox = cont + 4'd1;
            end
          end else begin
            descarte_prox = 1'b1;
          end
        end
      end
      FALHA: begin
        if (start_sub) proximo = OCIOSO;
      end
      default: proximo = OCIOSO;
    endcase

    // Timer restarts from zero on every state entry.
    if (proximo == atual && (atual == ENCHENDO || atual == VEDANDO))
      timer_prox = timer + TW'(1);
  end

  assign motor       = (atual == ESTEIRA);
  assign valvula     = (atual == ENCHENDO);
  assign vedacao     = (atual == VEDANDO);
  assign alarme      = (atual == FALHA);
  assign estado      = atual;
  assign garrafas    = cont;
  assign descarte    = descarte_r;
  assign pulso_duzia = pulso_r;

endmodule

// File: tb/tb_controle_envase.sv
module tb_controle_envase;
  import envase_pkg::*;

  localparam int unsigned TE = 20;
  localparam int unsigned TV = 5;

  logic       clk = 1'b0;
  logic       reset, start, stop, sensor_posicao, sensor_nivel;
  logic       cq_valido, cq_aprovado;
  logic       motor, valvula, vedacao, descarte, pulso_duzia, alarme;
  logic [3:0] garrafas;
  logic [2:0] estado;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Reference model: approved bottles since the last clear, expected pulses.
  int unsigned aprovadas = 0;
  int unsigned desc_esp = 0;
  int unsigned puls_esp = 0;
  int unsigned pulsos_mon = 0;
  int unsigned descartes_mon = 0;

  controle_envase #(.T_ENCHER_MAX(TE), .T_VEDAR(TV)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .sensor_posicao(sensor_posicao), .sensor_nivel(sensor_nivel),
    .cq_valido(cq_valido), .cq_aprovado(cq_aprovado),
    .motor(motor), .valvula(valvula), .vedacao(vedacao),
    .descarte(descarte), .pulso_duzia(pulso_duzia), .garrafas(garrafas),
    .alarme(alarme), .estado(estado)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (pulso_duzia === 1'b1) pulsos_mon++;
    if (descarte === 1'b1) descartes_mon++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] observado,
                     input logic [31:0] esperado);
    checks++;
    assert (observado === esperado) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observado, esperado);
    end
  endtask

  task automatic ciclos(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic saidas_zero(input string tag);
    chk({tag, "_estado"}, estado, OCIOSO);
    chk({tag, "_motor"}, motor, 0);
    chk({tag, "_valvula"}, valvula, 0);
    chk({tag, "_vedacao"}, vedacao, 0);
    chk({tag, "_descarte"}, descarte, 0);
    chk({tag, "_pulso"}, pulso_duzia, 0);
    chk({tag, "_garrafas"}, garrafas, 0);
    chk({tag, "_alarme"}, alarme, 0);
  endtask

  // From ESTEIRA: bottle arrives, level reached d clocks after the raw
  // position edge; returns at the first sample in INSPECAO.
  task automatic enche(input int unsigned d);
    int unsigned k, n_val, n_ved;
    bit chegou;
    chk("motor_antes_garrafa", motor, 1);
    sensor_posicao = 1'b1;
    k = 0; n_val = 0; n_ved = 0; chegou = 0;
    while (!chegou && k < 80) begin
      if (k == d) sensor_nivel = 1'b1;
      @(negedge clk);
      k++;
      if (valvula === 1'b1) n_val++;
      if (vedacao === 1'b1) n_ved++;
      if (estado === INSPECAO) chegou = 1;
    end
    chk("ciclos_valvula", n_val, d);
    chk("ciclos_vedacao", n_ved, TV);
    chk("latencia_inspecao", k, d + 3 + TV);
    sensor_posicao = 1'b0;
    sensor_nivel = 1'b0;
  endtask

  task automatic veredito(input bit aprova);
    bit pulso_esp;
    cq_valido = 1'b1;
    cq_aprovado = aprova;
    ciclos(2);
    chk("inspecao_aguarda", estado, INSPECAO);
    ciclos(1);
    pulso_esp = 0;
    if (aprova) begin
      aprovadas++;
      pulso_esp = (aprovadas % 12 == 0);
    end else begin
      desc_esp++;
    end
    if (pulso_esp) puls_esp++;
    chk("estado_pos_veredito", estado, ESTEIRA);
    chk("descarte", descarte, !aprova);
    chk("pulso_duzia", pulso_duzia, pulso_esp);
    chk("garrafas", garrafas, aprovadas % 12);
    chk("motor_retorno", motor, 1);
    ciclos(1);
    chk("descarte_um_ciclo", descarte, 0);
    chk("pulso_um_ciclo", pulso_duzia, 0);
    cq_valido = 1'b0;
    cq_aprovado = 1'b0;
    ciclos(3);
  endtask

  task automatic garrafa(input bit aprova, input int unsigned d);
    enche(d);
    veredito(aprova);
    ciclos($urandom_range(0, 3));
  endtask

  task automatic pulsa_start();
    start = 1'b1;
    ciclos(3);
    start = 1'b0;
  endtask

  initial begin
    int unsigned n;
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    sensor_posicao = 1'b0; sensor_nivel = 1'b0;
    cq_valido = 1'b0; cq_aprovado = 1'b0;
    ciclos(2);
    saidas_zero("reset");
    reset = 1'b0;
    ciclos(2);

    // start and stop together while idle: stays idle
    start = 1'b1; stop = 1'b1;
    ciclos(4);
    chk("start_stop_ocioso", estado, OCIOSO);
    chk("start_stop_motor", motor, 0);
    start = 1'b0; stop = 1'b0;
    ciclos(3);

    // start latency: 3 clocks
    start = 1'b1;
    ciclos(2);
    chk("start_latencia_2", estado, OCIOSO);
    ciclos(1);
    chk("start_esteira", estado, ESTEIRA);
    chk("start_motor", motor, 1);
    chk("start_garrafas", garrafas, 0);
    start = 1'b0;
    aprovadas = 0;
    ciclos(3);

    // normal cycle, then complete the dozen
    enche(8);
    veredito(1'b1);
    for (int i = 0; i < 11; i++) garrafa(1'b1, $urandom_range(1, 15));
    ciclos(2);
    chk("pulsos_duzia", pulsos_mon, 1);
    chk("descartes_duzia", descartes_mon, 0);

    // reject pattern: 3 approved, 1 rejected, 1 approved
    for (int i = 0; i < 3; i++) garrafa(1'b1, $urandom_range(1, 15));
    garrafa(1'b0, $urandom_range(1, 15));
    garrafa(1'b1, $urandom_range(1, 15));
    chk("garrafas_rejeicao", garrafas, 4);
    chk("descartes_rejeicao", descartes_mon, 1);

    // randomized mix
    for (int i = 0; i < 10; i++)
      garrafa($urandom_range(0, 3) != 0, $urandom_range(1, 19));

    // stop coincident with verdict
    enche($urandom_range(1, 10));
    cq_valido = 1'b1; cq_aprovado = 1'b1; stop = 1'b1;
    ciclos(3);
    chk("stopver_estado", estado, OCIOSO);
    chk("stopver_garrafas", garrafas, aprovadas % 12);
    chk("stopver_pulso", pulso_duzia, 0);
    chk("stopver_descarte", descarte, 0);
    cq_valido = 1'b0; cq_aprovado = 1'b0; stop = 1'b0;
    ciclos(3);
    chk("stopver_pulsos", pulsos_mon, puls_esp);
    chk("stopver_descartes", descartes_mon, desc_esp);

    // restart clears the count
    pulsa_start();
    chk("restart_estado", estado, ESTEIRA);
    chk("restart_garrafas", garrafas, 0);
    aprovadas = 0;
    ciclos(3);
    garrafa(1'b1, 4);

    // stop during filling
    sensor_posicao = 1'b1;
    ciclos(3);
    chk("stop_enchendo", estado, ENCHENDO);
    chk("stop_valvula_antes", valvula, 1);
    ciclos(2);
    stop = 1'b1;
    ciclos(2);
    chk("stop_latencia_2", estado, ENCHENDO);
    ciclos(1);
    chk("stop_estado", estado, OCIOSO);
    chk("stop_valvula", valvula, 0);
    chk("stop_motor", motor, 0);
    chk("stop_garrafas", garrafas, aprovadas % 12);
    stop = 1'b0; sensor_posicao = 1'b0;
    ciclos(3);
    pulsa_start();
    chk("stop_restart_estado", estado, ESTEIRA);
    chk("stop_restart_garrafas", garrafas, 0);
    aprovadas = 0;
    ciclos(3);

    // fill timeout
    sensor_posicao = 1'b1;
    ciclos(3);
    chk("timeout_enchendo", estado, ENCHENDO);
    n = 0;
    while (estado === ENCHENDO && n < 60) begin
      ciclos(1);
      n++;
    end
    chk("timeout_ciclos", n, TE);
    chk("timeout_estado", estado, FALHA);
    chk("timeout_alarme", alarme, 1);
    chk("timeout_valvula", valvula, 0);
    chk("timeout_motor", motor, 0);
    stop = 1'b1;
    ciclos(4);
    chk("falha_ignora_stop", estado, FALHA);
    chk("falha_alarme_stop", alarme, 1);
    stop = 1'b0;
    ciclos(3);
    pulsa_start();
    chk("falha_start_estado", estado, OCIOSO);
    chk("falha_start_alarme", alarme, 0);
    sensor_posicao = 1'b0;
    ciclos(3);

    // asynchronous reset while capping
    pulsa_start();
    chk("pre_reset_estado", estado, ESTEIRA);
    ciclos(3);
    sensor_posicao = 1'b1;
    n = 0;
    while (vedacao !== 1'b1 && n < 40) begin
      if (n == 2) sensor_nivel = 1'b1;
      ciclos(1);
      n++;
    end
    chk("vedando_atingido", vedacao, 1);
    ciclos(2);
    #3;
    reset = 1'b1;
    #1;
    saidas_zero("reset_async");
    ciclos(2);
    reset = 1'b0;
    sensor_posicao = 1'b0; sensor_nivel = 1'b0;
    ciclos(3);
    chk("pos_reset_estado", estado, OCIOSO);

    chk("total_pulsos", pulsos_mon, puls_esp);
    chk("total_descartes", descartes_mon, desc_esp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
